// File: rtl/frame_det_pkg.sv
// -----------------------------------------------------------------------------
// frame_det_pkg
// Shared definitions for the frame-sync detector slice:
//   - lock FSM state encodings (2-bit, legacy-compatible constants)
//   - parameter legality check used at elaboration by the top level
// -----------------------------------------------------------------------------
package frame_det_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_HUNT    = 2'd0;
  localparam fsm_state_t ST_CONFIRM = 2'd1;
  localparam fsm_state_t ST_LOCKED  = 2'd2;

  // True when the parameter set describes a buildable detector.
  function automatic bit params_legal(input int pw, input int frame_len,
                                      input int lock_n, input int unlock_n,
                                      input int cnt_w);
    return (pw >= 2) && (pw <= 32) && (frame_len >= pw) &&
           (lock_n >= 1) && (unlock_n >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/frame_sync_detector_if.sv
// -----------------------------------------------------------------------------
// frame_sync_detector_if
// Bit-stream, configuration and status bundle of the frame-sync detector.
//   IN_VALID / IN_DATA      : serial bit stream, one bit per valid cycle
//   CFG_PAT / CFG_MASK      : pattern and compare mask (1 = compare bit)
//   OVERLAP                 : 1 = overlapping match reporting
//   PDET / MATCH_CNT        : match pulse and saturating match count
//   LOCK / SOF              : frame alignment status and start-of-frame pulse
// master = stream source / software side, slave = detector.
// -----------------------------------------------------------------------------
interface frame_sync_detector_if #(
  parameter int PW    = 4,
  parameter int CNT_W = 8
) ();

  logic             IN_VALID;
  logic             IN_DATA;
  logic [PW-1:0]    CFG_PAT;
  logic [PW-1:0]    CFG_MASK;
  logic             OVERLAP;
  logic             PDET;
  logic [CNT_W-1:0] MATCH_CNT;
  logic             LOCK;
  logic             SOF;

  modport master (
    output IN_VALID, IN_DATA, CFG_PAT, CFG_MASK, OVERLAP,
    input  PDET, MATCH_CNT, LOCK, SOF
  );

  modport slave (
    input  IN_VALID, IN_DATA, CFG_PAT, CFG_MASK, OVERLAP,
    output PDET, MATCH_CNT, LOCK, SOF
  );

endinterface

// File: rtl/pattern_match_core.sv
// -----------------------------------------------------------------------------
// pattern_match_core
// Serial shift register, fill counter and masked pattern compare.
// Ports:
//   clk, aclr (async, active-high), sclr (sync clear, wins over in_valid)
//   in_valid, in_data : serial bit stream, first bit ends up in sh[PW-1]
//   cfg_pat, cfg_mask : pattern and compare mask (1 = compare)
//   raw_match         : combinational, high while an accepted bit completes
//                       a window that matches under the mask
// -----------------------------------------------------------------------------
module pattern_match_core
  import frame_det_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          sclr,
  input  logic          in_valid,
  input  logic          in_data,
  input  logic [PW-1:0] cfg_pat,
  input  logic [PW-1:0] cfg_mask,
  output logic          raw_match
);

  localparam int                FILL_W   = $clog2(PW + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PW);
  // The window is complete once this bit lands on top of PW-1 earlier bits.
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PW - 1);

  logic [PW-1:0]     sh_q, sh_d, sh_next;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    sh_next   = {sh_q[PW-2:0], in_data};
    sh_d      = sh_q;
    fill_d    = fill_q;
    raw_match = 1'b0;
    if (sclr) begin
      sh_d   = '0;
      fill_d = '0;
    end else if (in_valid) begin
      sh_d = sh_next;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
      raw_match = (fill_q >= FILL_ARM) &&
                  (((sh_next ^ cfg_pat) & cfg_mask) == '0);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sh_q   <= '0;
      fill_q <= '0;
    end else begin
      sh_q   <= sh_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/frame_sync_detector.sv
// -----------------------------------------------------------------------------
// frame_sync_detector
// Serial frame-sync detector: programmable pattern/mask match, overlap or
// non-overlap match reporting, saturating match counter and a
// hunt/confirm/lock frame-alignment FSM with flywheel SOF generation.
// Ports:
//   CLK  : clock, rising edge
//   ACLR : asynchronous active-high reset
//   SCLR : synchronous clear (same effect as ACLR, drops a bit in flight)
//   bus  : frame_sync_detector_if.slave (stream in, config in, status out)
// Outputs PDET, SOF and LOCK are registered: one cycle after the edge that
// accepts the completing bit.
// -----------------------------------------------------------------------------
module frame_sync_detector
  import frame_det_pkg::*;
#(
  parameter int PW        = 4,
  parameter int FRAME_LEN = 16,
  parameter int LOCK_N    = 3,
  parameter int UNLOCK_N  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                  CLK,
  input  logic                  ACLR,
  input  logic                  SCLR,
  frame_sync_detector_if.slave  bus
);

  if (!params_legal(PW, FRAME_LEN, LOCK_N, UNLOCK_N, CNT_W)) begin : g_bad_params
    $error("frame_sync_detector: illegal parameter combination");
  end

  localparam int HOLD_W = $clog2(PW + 1);
  localparam int POS_W  = $clog2(FRAME_LEN + 1);
  localparam int HIT_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(UNLOCK_N + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PW - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic raw_match;

  pattern_match_core #(
    .PW (PW)
  ) u_core (
    .clk       (CLK),
    .aclr      (ACLR),
    .sclr      (SCLR),
    .in_valid  (bus.IN_VALID),
    .in_data   (bus.IN_DATA),
    .cfg_pat   (bus.CFG_PAT),
    .cfg_mask  (bus.CFG_MASK),
    .raw_match (raw_match)
  );

  fsm_state_t        state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic [MISS_W-1:0] misses_q, misses_d;
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pdet_q, pdet_d;
  logic              sof_q, sof_d;
  logic              lock_q, lock_d;
  logic              is_check;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    holdoff_d = holdoff_q;
    cnt_d     = cnt_q;
    pdet_d    = 1'b0;
    sof_d     = 1'b0;
    // pos holds the number of valid bits already taken since the anchor, so
    // the bit arriving while pos == FRAME_LEN-1 is one full frame later.
    is_check  = (pos_q == POS_LAST);

    if (SCLR) begin
      state_d   = ST_HUNT;
      pos_d     = '0;
      hits_d    = '0;
      misses_d  = '0;
      holdoff_d = '0;
      cnt_d     = '0;
    end else if (bus.IN_VALID) begin
      // Match reporting: holdoff suppresses reports that would reuse bits of
      // the previous reported pattern in non-overlap mode.
      pdet_d = raw_match && (holdoff_q == '0);
      if (pdet_d && !bus.OVERLAP) begin
        holdoff_d = HOLD_LOAD;
      end else if (holdoff_q != '0) begin
        holdoff_d = holdoff_q - HOLD_W'(1);
      end
      if (pdet_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // Lock FSM runs on the raw match so it is independent of OVERLAP.
      case (state_q)
        ST_HUNT: begin
          if (raw_match) begin
            pos_d    = '0;
            hits_d   = HIT_W'(1);
            misses_d = '0;
            state_d  = (LOCK_N == 1) ? ST_LOCKED : ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (is_check) begin
            pos_d = '0;
            if (raw_match) begin
              if (int'(hits_q) + 1 >= LOCK_N) begin
                state_d  = ST_LOCKED;
                misses_d = '0;
              end else begin
                hits_d = hits_q + HIT_W'(1);
              end
            end else begin
              state_d = ST_HUNT;
              hits_d  = '0;
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        ST_LOCKED: begin
          if (is_check) begin
            pos_d = '0;
            // Flywheel: SOF marks the expected position even on a miss.
            sof_d = 1'b1;
            if (raw_match) begin
              misses_d = '0;
            end else if (int'(misses_q) + 1 >= UNLOCK_N) begin
              state_d  = ST_HUNT;
              misses_d = '0;
              hits_d   = '0;
            end else begin
              misses_d = misses_q + MISS_W'(1);
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      state_q   <= ST_HUNT;
      pos_q     <= '0;
      hits_q    <= '0;
      misses_q  <= '0;
      holdoff_q <= '0;
      cnt_q     <= '0;
      pdet_q    <= 1'b0;
      sof_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hits_q    <= hits_d;
      misses_q  <= misses_d;
      holdoff_q <= holdoff_d;
      cnt_q     <= cnt_d;
      pdet_q    <= pdet_d;
      sof_q     <= sof_d;
      lock_q    <= lock_d;
    end
  end

  assign bus.PDET      = pdet_q;
  assign bus.MATCH_CNT = cnt_q;
  assign bus.LOCK      = lock_q;
  assign bus.SOF       = sof_q;

endmodule

// File: doc/frame_sync_detector.md
# frame_sync_detector

Parametrised serial frame-sync detector for the Frame_Detector path. It generalises the fixed 4-bit "1010" detector to any pattern width, with a runtime-programmable pattern and don't-care mask, overlap/non-overlap reporting, a saturating match counter and a hunt/confirm/lock frame-alignment state machine. It sits directly on the recovered serial bit stream and feeds frame-aligned downstream logic through `LOCK` and `SOF`.

## Interface
- `PW`, 4: pattern width in bits; legal range 2..32.
- `FRAME_LEN`, 16: bits between consecutive pattern ends; must be ≥ `PW`.
- `LOCK_N`, 3: consecutive on-position hits needed to lock; ≥ 1.
- `UNLOCK_N`, 2: consecutive on-position misses that drop lock; ≥ 1.
- `CNT_W`, 8: `MATCH_CNT` width.
- `CLK` in 1: single clock; all logic on the rising edge.
- `ACLR` in 1: reset, asynchronous, active-high.
- `SCLR` in 1: synchronous clear, same effect as `ACLR` but on a clock edge.
- `IN_VALID` in 1: `IN_DATA` is a new bit this cycle.
- `IN_DATA` in 1: serial bit, MSB of the pattern first.
- `CFG_PAT` in PW: pattern to match; bit PW-1 is the first bit received.
- `CFG_MASK` in PW: 1 = compare this bit, 0 = don't care.
- `OVERLAP` in 1: 1 = overlapping matches reported; 0 = non-overlapping.
- `PDET` out 1: one-cycle match pulse.
- `MATCH_CNT` out CNT_W: saturating count of `PDET` pulses.
- `LOCK` out 1: high while the FSM is in LOCKED.
- `SOF` out 1: one-cycle pulse at each expected frame position while LOCKED.

## Operation
- Shift register `sh`: on `IN_VALID`, `sh <= {sh[PW-2:0], IN_DATA}`. Fill counter saturates at PW and is cleared only by `ACLR`/`SCLR`.
- Raw match: on an accepted bit with fill already at PW-1 or more, `((sh_next ^ CFG_PAT) & CFG_MASK) == 0`. A mask of all zeros matches every bit once fill is satisfied.
- Reported match:
  - `PDET` = raw match AND holdoff == 0.
  - When `OVERLAP=0`, a reported match loads holdoff with PW-1. Holdoff decrements on each valid bit.
  - When `OVERLAP=1`, holdoff stays 0.
- `MATCH_CNT` increments on `PDET`, saturates at 2^CNT_W-1, and is cleared by reset/`SCLR`.
- The lock FSM uses the raw match, so it is independent of `OVERLAP`. `pos` counts valid bits since the anchor. A check bit is the valid bit at which `pos == FRAME_LEN-1`; at the check bit `pos` returns to 0.
  - HUNT: raw match → CONFIRM, `pos` ← 0, hits ← 1 (if `LOCK_N == 1`, go directly to LOCKED).
  - CONFIRM: check bit with a match → hits+1; hits reaching `LOCK_N` → LOCKED. Check bit without a match → HUNT. Matches off the check bit are ignored.
  - LOCKED: check bit with a match → misses ← 0. Check bit without a match → misses+1; misses reaching `UNLOCK_N` → HUNT. `SOF` pulses on every check bit in LOCKED, hit or miss (flywheel).
- `CFG_PAT`, `CFG_MASK` and `OVERLAP` are used live. Software changes them only with a following `SCLR`.

## Timing
- Reset values: `PDET`=0, `MATCH_CNT`=0, `LOCK`=0, `SOF`=0. FSM in HUNT; `sh`, fill, holdoff, `pos`, hits and misses all 0.
- `PDET`, `SOF` and `LOCK` are registered. Each asserts in the cycle after the edge that accepted the completing bit, which is one cycle of latency.
- `MATCH_CNT` updates on the same edge that asserts `PDET`.
- `IN_VALID=0`: all state holds and `PDET`/`SOF` are 0.
- `SCLR` with `IN_VALID` in the same cycle: `SCLR` wins and the bit is discarded.
- `ACLR` mid-pattern: partial history is lost, and a full PW fresh bits are needed before any match.
- `LOCK` falls in the cycle after the `UNLOCK_N`-th miss is accepted. `SOF` still pulses for that final check bit.

## Structure
- Shared package `frame_det_pkg`: FSM state encodings `ST_HUNT`, `ST_CONFIRM`, `ST_LOCKED` (2 bits) and the parameter legality check.
- Sub-module `pattern_match_core`: shift register, fill counter and masked compare; outputs the raw match.
- Top level: holdoff, counter, lock FSM and outputs.

## Test plan
All scenarios use `PW`=4, `CFG_PAT`=1010, `CFG_MASK`=1111, `FRAME_LEN`=16, `LOCK_N`=3, `UNLOCK_N`=2 unless stated.
- Stream 1,0,1,0,1,0 with `OVERLAP=1` → `PDET` after bits 4 and 6, `MATCH_CNT`=2. Same stream with `OVERLAP=0` → only bit 4, `MATCH_CNT`=1.
- Send 1,0,1, pulse `ACLR`, then send 0 → no `PDET`. Then send 1,0,1,0 → `PDET` after the 4th bit.
- `CFG_MASK`=1011 with stream 1,1,1,0 → `PDET`. Stream 1,1,0,0 → no `PDET`.
- Pattern ending at bit positions 4, 20, 36 with random fill bits that contain no 1010 → `LOCK` rises after bit 36. `SOF` pulses at 52 and 68 while the pattern continues.
- While locked: one missed check then a hit → `LOCK` stays high. Two consecutive misses → `LOCK` low after the second; `SOF` pulsed for both misses.
- `CNT_W`=2 with 5 matches → `MATCH_CNT` holds 3. `SCLR` with `IN_VALID=1` → `MATCH_CNT`=0, bit dropped, FSM in HUNT.
